// File: rtl/cpu_boot_ctrl_pkg.sv
// Shared types and constants for the CPU boot/run sequencer.
package cpu_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RST_HOLD,
    RUN,
    DONE
  } state_t;

  localparam int TGT_IMEM = 0;
  localparam int TGT_DMEM = 1;
  localparam int TGT_REG  = 2;

  localparam int NUM_TGT_DEF = TGT_REG - TGT_IMEM + 1;

endpackage

// File: rtl/cpu_boot_ctrl_if.sv
// Program-image load port: valid/ready handshake with target, address, data and last flag.
interface cpu_boot_ctrl_if #(
  parameter int TGT_W  = 2,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [TGT_W-1:0]  tgt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, tgt, addr, data, last, input ready);
  modport slave  (input valid, tgt, addr, data, last, output ready);
endinterface

// File: rtl/cpu_boot_ctrl_timer.sv
// Shared counter: counts down for the reset-hold length, up for the CPU run length.
module cpu_boot_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] tc,
  output logic [W-1:0] cnt,
  output logic         hit
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= up ? cnt + W'(1) : cnt - W'(1);
    end
  end

  assign hit = (cnt == tc);

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot/run sequencer: loads a program image, holds CPU reset, runs it for a programmed count.
// Optional CPU halt detection is enabled by defining CPU_HALT_DETECT_EN.
module cpu_boot_ctrl
  import cpu_boot_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int NUM_TGT   = NUM_TGT_DEF,
  parameter int RESET_CYC = 4,
  parameter int RUN_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [RUN_W-1:0]   run_cycles,
  cpu_boot_ctrl_if.slave     ld,
  output logic [NUM_TGT-1:0] mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               cpu_resetn,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [RUN_W-1:0]   cycle_cnt
`ifdef CPU_HALT_DETECT_EN
  ,
  input  logic               cpu_halt,
  output logic               halted
`endif
);

  localparam int TGT_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam logic [TGT_W:0] NUM_TGT_C = (TGT_W + 1)'(NUM_TGT);
  localparam logic [RUN_W-1:0] HOLD_INIT = RUN_W'(RESET_CYC - 1);

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q;
  logic             accept, start_go, halt_req;
  logic             t_load, t_en, t_up, t_hit;
  logic [RUN_W-1:0] t_val, t_tc, t_cnt;

`ifdef CPU_HALT_DETECT_EN
  assign halt_req = cpu_halt;
`else
  assign halt_req = 1'b0;
`endif

  assign ld.ready   = (state_q == LOAD);
  assign accept     = ld.valid & ld.ready;
  assign start_go   = start & ((state_q == IDLE) | (state_q == DONE));
  assign cpu_resetn = (state_q == RUN);
  assign busy       = (state_q != IDLE) & (state_q != DONE);
  assign done       = (state_q == DONE);
  // The shared counter only means "cycles run" once RUN has been entered.
  assign cycle_cnt  = ((state_q == RUN) | (state_q == DONE)) ? t_cnt : '0;

  cpu_boot_timer #(.W(RUN_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .en       (t_en),
    .up       (t_up),
    .load_val (t_val),
    .tc       (t_tc),
    .cnt      (t_cnt),
    .hit      (t_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    t_load  = 1'b0;
    t_en    = 1'b0;
    t_up    = 1'b1;
    t_val   = '0;
    t_tc    = '0;
    case (state_q)
      IDLE, DONE: if (start) state_d = LOAD;
      LOAD: begin
        if (accept && ld.last) begin
          state_d = RST_HOLD;
          t_load  = 1'b1;
          t_val   = HOLD_INIT;
        end
      end
      RST_HOLD: begin
        if (t_hit) begin
          t_load  = 1'b1;
          state_d = (run_q == '0) ? DONE : RUN;
        end else begin
          t_en = 1'b1;
          t_up = 1'b0;
        end
      end
      RUN: begin
        // Hitting run_q-1 on this edge leaves cycle_cnt == run_q in DONE.
        t_tc = run_q - RUN_W'(1);
        t_en = 1'b1;
        if (t_hit || halt_req) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
      run_q     <= '0;
    end else begin
      mem_we <= '0;
      if (accept) begin
        if ({1'b0, ld.tgt} < NUM_TGT_C) begin
          mem_we    <= NUM_TGT'(1) << ld.tgt;
          mem_addr  <= ld.addr;
          mem_wdata <= ld.data;
        end else begin
          err <= 1'b1;
        end
        if (ld.last) run_q <= run_cycles;
      end
      if (start_go) err <= 1'b0;
    end
  end

`ifdef CPU_HALT_DETECT_EN
  always_ff @(posedge clk) begin
    if (reset)                             halted <= 1'b0;
    else if (start_go)                     halted <= 1'b0;
    else if (state_q == RUN && cpu_halt)   halted <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Randomized self-checking bench for cpu_boot_ctrl against a phase-level model.
// Halt tests are included when CPU_HALT_DETECT_EN is defined.
module tb_cpu_boot_ctrl;
  import cpu_boot_pkg::*;

  localparam int ADDR_W = 10, DATA_W = 32, NUM_TGT = 3, RESET_CYC = 4, RUN_W = 16;
  localparam int P_IDLE = 0, P_LOAD = 1, P_HOLD = 2, P_RUN = 3, P_DONE = 4;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [RUN_W-1:0]   run_cycles = '0, cycle_cnt;
  logic [NUM_TGT-1:0] mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic cpu_resetn, busy, done, err;
`ifdef CPU_HALT_DETECT_EN
  logic cpu_halt = 1'b0, halted;
`endif

  cpu_boot_ctrl_if #(.TGT_W(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) ld_if ();

  cpu_boot_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_TGT(NUM_TGT),
                  .RESET_CYC(RESET_CYC), .RUN_W(RUN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .run_cycles(run_cycles), .ld(ld_if),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_resetn(cpu_resetn), .busy(busy), .done(done), .err(err), .cycle_cnt(cycle_cnt)
`ifdef CPU_HALT_DETECT_EN
    , .cpu_halt(cpu_halt), .halted(halted)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Phase-level model: tracks remaining hold cycles and elapsed run cycles directly.
  int m_ph = P_IDLE, m_hold = 0;
  int unsigned m_cyc = 0, m_run = 0;
  bit m_err = 0, m_halted = 0;
  logic [NUM_TGT-1:0] m_we = '0;
  logic [ADDR_W-1:0]  m_addr = '0;
  logic [DATA_W-1:0]  m_data = '0;

  always @(posedge clk) begin
    logic [NUM_TGT-1:0] we_n;
    bit h;
    h = 1'b0;
`ifdef CPU_HALT_DETECT_EN
    h = cpu_halt;
`endif
    we_n = '0;
    if (reset) begin
      m_ph = P_IDLE; m_err = 0; m_cyc = 0; m_halted = 0;
      m_addr = '0; m_data = '0;
    end else begin
      case (m_ph)
        P_IDLE, P_DONE:
          if (start) begin m_ph = P_LOAD; m_err = 0; m_cyc = 0; m_halted = 0; end
        P_LOAD:
          if (ld_if.valid) begin
            if (ld_if.tgt < NUM_TGT) begin
              we_n[ld_if.tgt] = 1'b1; m_addr = ld_if.addr; m_data = ld_if.data;
            end else m_err = 1;
            if (ld_if.last) begin m_run = run_cycles; m_hold = RESET_CYC; m_ph = P_HOLD; end
          end
        P_HOLD: begin
          m_hold--;
          if (m_hold == 0) m_ph = (m_run == 0) ? P_DONE : P_RUN;
        end
        P_RUN: begin
          m_cyc++;
          if (m_cyc == m_run || h) begin m_ph = P_DONE; if (h) m_halted = 1; end
        end
        default: m_ph = P_IDLE;
      endcase
    end
    m_we = we_n;
  end

  int rn_hi = 0, hold_cyc = 0, we_cyc = 0, cyc_no = 0, we_first = -1, we_last = -1;

  always @(negedge clk) begin
    cyc_no++;
    if (chk_on) begin
      chk("busy", busy, (m_ph == P_LOAD || m_ph == P_HOLD || m_ph == P_RUN));
      chk("done", done, (m_ph == P_DONE));
      chk("ld_ready", ld_if.ready, (m_ph == P_LOAD));
      chk("cpu_resetn", cpu_resetn, (m_ph == P_RUN));
      chk("err", err, m_err);
      chk("cycle_cnt", cycle_cnt, m_cyc);
      chk("mem_we", mem_we, m_we);
      if (m_we != '0) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_data);
      end
`ifdef CPU_HALT_DETECT_EN
      chk("halted", halted, m_halted);
`endif
    end
    if (cpu_resetn) rn_hi++;
    if (busy && !ld_if.ready && !cpu_resetn) hold_cyc++;
    if (mem_we != '0) begin
      we_cyc++;
      if (we_first < 0) we_first = cyc_no;
      we_last = cyc_no;
    end
  end

  task automatic clr_mon();
    rn_hi = 0; hold_cyc = 0; we_cyc = 0; we_first = -1; we_last = -1;
  endtask

  task automatic check_reset_lit(input string tag);
    chk({tag, "_ready"}, ld_if.ready, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_resetn"}, cpu_resetn, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_cnt"}, cycle_cnt, 0);
`ifdef CPU_HALT_DETECT_EN
    chk({tag, "_halted"}, halted, 0);
`endif
  endtask

  task automatic do_start(input bit noise);
    start = 1'b1;
    if (noise) begin ld_if.valid = 1'b1; ld_if.last = 1'b1; end
    @(negedge clk);
    start = 1'b0; ld_if.valid = 1'b0; ld_if.last = 1'b0;
  endtask

  task automatic beat(input logic [1:0] t, input int a, input logic [31:0] d,
                      input bit l, input int rc);
    ld_if.valid = 1'b1; ld_if.tgt = t; ld_if.addr = ADDR_W'(a);
    ld_if.data = d; ld_if.last = l; run_cycles = RUN_W'(rc);
    @(negedge clk);
    ld_if.valid = 1'b0; ld_if.last = 1'b0;
  endtask

  task automatic run_to_done(input int budget, input bit noisy);
    int k = 0;
    while (!done && k < budget) begin
      start = noisy && ($urandom_range(0, 7) == 0);
`ifdef CPU_HALT_DETECT_EN
      cpu_halt = noisy && cpu_resetn && ($urandom_range(0, 29) == 0);
`endif
      @(negedge clk);
      k++;
    end
    start = 1'b0;
`ifdef CPU_HALT_DETECT_EN
    cpu_halt = 1'b0;
`endif
    if (!done) begin
      n_checks++; n_err++;
      $display("FAIL run_to_done: got done=0 expected done=1 within %0d cycles", budget);
    end
  endtask

  task automatic wait_cnt(input int val, input int budget);
    int k = 0;
    while (cycle_cnt != RUN_W'(val) && k < budget) begin @(negedge clk); k++; end
    if (cycle_cnt != RUN_W'(val)) begin
      n_checks++; n_err++;
      $display("FAIL wait_cnt: got %0d expected %0d within %0d cycles", cycle_cnt, val, budget);
    end
  endtask

  initial begin
    ld_if.valid = 1'b0; ld_if.tgt = '0; ld_if.addr = '0; ld_if.data = '0; ld_if.last = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk_on = 1;
    check_reset_lit("init");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Two-beat image, 100-cycle run
    clr_mon();
    do_start(0);
    beat(2'(TGT_IMEM), 0, 32'h2001_0005, 0, 7);
    repeat (2) @(negedge clk);
    beat(2'(TGT_DMEM), 3, 32'hDEAD_BEEF, 1, 100);
    run_to_done(300, 0);
    chk("t2_resetn_hi", rn_hi, 100);
    chk("t2_hold", hold_cyc, 4);
    chk("t2_cnt", cycle_cnt, 100);
    chk("t2_writes", we_cyc, 2);
    chk("t2_gap", we_last - we_first, 3);
    chk("t2_done", done, 1);

    // Eight back-to-back beats
    clr_mon();
    do_start(0);
    for (int i = 0; i < 8; i++)
      beat(2'($urandom_range(0, 2)), 16 + i, $urandom, i == 7, 5);
    run_to_done(100, 0);
    chk("t3_writes", we_cyc, 8);
    chk("t3_span", we_last - we_first + 1, 8);

    // Invalid target on the last beat
    clr_mon();
    do_start(0);
    beat(2'd3, 5, 32'h1234_5678, 1, 3);
    run_to_done(100, 0);
    chk("t4_err", err, 1);
    chk("t4_writes", we_cyc, 0);
    chk("t4_done", done, 1);
    do_start(0);
    chk("t4_err_clr", err, 0);

    // Zero-length run
    clr_mon();
    beat(2'(TGT_REG), 7, 32'hCAFE_F00D, 1, 0);
    run_to_done(50, 0);
    chk("t5_resetn_hi", rn_hi, 0);
    chk("t5_cnt", cycle_cnt, 0);
    chk("t5_done", done, 1);

    // Reset held three cycles in the middle of a run
    do_start(0);
    beat(2'(TGT_IMEM), 1, 32'h0000_0001, 1, 50);
    wait_cnt(10, 50);
    reset = 1'b1;
    @(negedge clk);
    check_reset_lit("t1");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_done", done, 0);

`ifdef CPU_HALT_DETECT_EN
    do_start(0);
    beat(2'(TGT_IMEM), 2, 32'h0000_0002, 1, 100);
    wait_cnt(9, 50);
    cpu_halt = 1'b1; start = 1'b1;
    @(negedge clk);
    cpu_halt = 1'b0; start = 1'b0;
    chk("t6_done", done, 1);
    chk("t6_halted", halted, 1);
    chk("t6_cnt", cycle_cnt, 10);
    @(negedge clk);
    chk("t6_still_done", done, 1);
    do_start(0);
    chk("t6_halted_clr", halted, 0);
    beat(2'(TGT_IMEM), 0, 32'h0, 1, 1);
    run_to_done(50, 0);
`endif

    // Randomized sessions
    for (int s = 0; s < 25; s++) begin
      int nb;
      do_start($urandom_range(0, 1) == 1);
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        int gap;
        logic [1:0] t;
        t = ($urandom_range(0, 4) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        beat(t, $urandom_range(0, 1023), $urandom, b == nb - 1, $urandom_range(0, 25));
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap && b != nb - 1; g++) begin
          start = ($urandom_range(0, 3) == 0);
          @(negedge clk);
          start = 1'b0;
        end
      end
      run_to_done(200, 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
